// File: rtl/opcodes.sv
// Shared encodings for the CPU slice: PC source select and the RAM
// arbiter ownership states used by ram_arbiter.
package opcodes;

  // Program counter source select used by control/datapath.
  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_HOLD   = 2'd3
  } PcSel_t;

  // RAM ownership states of the CPU/loader arbiter.
  typedef enum logic [1:0] {
    OWN_CPU  = 2'd0,
    OWN_LD   = 2'd1,
    HANDOVER = 2'd2
  } arb_state_t;

  // Even parity of an 8-bit value, available to memory-side checkers.
  function automatic logic parity8(input logic [7:0] value);
    parity8 = ^value;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single program/data RAM between the CPU and the
// external loader/debug port. The CPU owns the RAM by default; the loader
// takes it through OWN_LD and returns it through a one-cycle HANDOVER.
// Optional feature: define ARB_FAIR_EN to bound loader beats per grant
// (MaxHold) whenever the CPU is also requesting.
module ram_arbiter
  import opcodes::*;
#(
  parameter int n       = 8,
  parameter int MaxHold = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         CpuReq,
  input  logic [n-1:0] CpuAddr,
  output logic         CpuStall,
  output logic [n-1:0] CpuRData,
  input  logic         LdReq,
  input  logic         LdWe,
  input  logic [n-1:0] LdAddr,
  input  logic [n-1:0] LdWData,
  output logic         LdGnt,
  output logic [n-1:0] LdRData,
  output logic         LdValid,
  output logic [n-1:0] MemAddr,
  output logic [n-1:0] MemWData,
  output logic         MemWe,
  input  logic [n-1:0] MemRData
);

  // Legacy-compatible state constants, tied to the package enum encoding.
  localparam logic [1:0] ST_OWN_CPU  = OWN_CPU;
  localparam logic [1:0] ST_OWN_LD   = OWN_LD;
  localparam logic [1:0] ST_HANDOVER = HANDOVER;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       accept;
  logic       rd_accept;
  logic       force_exit;
  logic       enter_ld;

  // A loader beat is accepted only while the loader holds the grant.
  assign accept    = LdReq & (state == ST_OWN_LD);
  assign rd_accept = accept & ~LdWe;
  assign enter_ld  = (state != ST_OWN_LD) & (state_nxt == ST_OWN_LD);

`ifdef ARB_FAIR_EN
  localparam int CW = $clog2(MaxHold + 1);

  logic [CW-1:0] hold_cnt;

  // Preempt the loader on its last allowed beat only if the CPU is waiting.
  assign force_exit = (hold_cnt == CW'(MaxHold - 1)) & accept & CpuReq;

  // Beat counter: cleared on each new grant, saturates at MaxHold.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hold_cnt <= '0;
    end else if (enter_ld) begin
      hold_cnt <= '0;
    end else if (accept && (hold_cnt != CW'(MaxHold))) begin
      hold_cnt <= hold_cnt + CW'(1);
    end else begin
      hold_cnt <= hold_cnt;
    end
  end
`else
  // Strict loader priority: the grant ends only when LdReq drops.
  assign force_exit = 1'b0;
`endif

  // Next-state decode; CpuReq never blocks a loader request in OWN_CPU.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OWN_CPU: begin
        if (LdReq) begin
          state_nxt = ST_OWN_LD;
        end else begin
          state_nxt = ST_OWN_CPU;
        end
      end
      ST_OWN_LD: begin
        if (!LdReq || force_exit) begin
          state_nxt = ST_HANDOVER;
        end else begin
          state_nxt = ST_OWN_LD;
        end
      end
      ST_HANDOVER: begin
        state_nxt = ST_OWN_CPU;
      end
      default: begin
        state_nxt = ST_OWN_CPU;
      end
    endcase
  end

  // Ownership state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_OWN_CPU;
    end else begin
      state <= state_nxt;
    end
  end

  // Loader read data path: capture on accepted reads, pulse valid once.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      LdValid <= 1'b0;
      LdRData <= '0;
    end else begin
      LdValid <= rd_accept;
      if (rd_accept) begin
        LdRData <= MemRData;
      end else begin
        LdRData <= LdRData;
      end
    end
  end

  // Output decode: grant/stall from state only; RAM controls also follow inputs.
  always_comb begin
    MemAddr  = CpuAddr;
    MemWData = LdWData;
    MemWe    = 1'b0;
    LdGnt    = 1'b0;
    CpuStall = 1'b0;
    case (state)
      ST_OWN_CPU: begin
        MemAddr  = CpuAddr;
        MemWe    = 1'b0;
        LdGnt    = 1'b0;
        CpuStall = 1'b0;
      end
      ST_OWN_LD: begin
        MemAddr  = LdAddr;
        MemWe    = LdReq & LdWe;
        LdGnt    = 1'b1;
        CpuStall = 1'b1;
      end
      ST_HANDOVER: begin
        MemAddr  = CpuAddr;
        MemWe    = 1'b0;
        LdGnt    = 1'b0;
        CpuStall = 1'b1;
      end
      default: begin
        MemAddr  = CpuAddr;
        MemWe    = 1'b0;
        LdGnt    = 1'b0;
        CpuStall = 1'b1;
      end
    endcase
  end

  // The CPU sees the RAM read port directly; it ignores it while stalled.
  assign CpuRData = MemRData;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural
// asynchronous-read RAM. Fairness expectations follow ARB_FAIR_EN.
module tb_ram_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CpuReq;
  logic [7:0] CpuAddr;
  logic       CpuStall;
  logic [7:0] CpuRData;
  logic       LdReq;
  logic       LdWe;
  logic [7:0] LdAddr;
  logic [7:0] LdWData;
  logic       LdGnt;
  logic [7:0] LdRData;
  logic       LdValid;
  logic [7:0] MemAddr;
  logic [7:0] MemWData;
  logic       MemWe;
  logic [7:0] MemRData;

  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  int n_pass  = 0;
  int n_total = 0;

  ram_arbiter #(.n(8), .MaxHold(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .CpuReq(CpuReq), .CpuAddr(CpuAddr), .CpuStall(CpuStall), .CpuRData(CpuRData),
    .LdReq(LdReq), .LdWe(LdWe), .LdAddr(LdAddr), .LdWData(LdWData),
    .LdGnt(LdGnt), .LdRData(LdRData), .LdValid(LdValid),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWe(MemWe), .MemRData(MemRData)
  );

  always #5 Clock = ~Clock;

  // RAM model: asynchronous read, write at the clock edge; bench preload port.
  always @(posedge Clock) begin
    if (MemWe) mem[MemAddr] <= MemWData;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign MemRData = mem[MemAddr];

  task automatic nxt();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Sample in the middle of the current cycle (inputs change 1 time unit after the edge).
  task automatic mid();
    #3;
  endtask

  initial begin
    Reset = 1'b1; CpuReq = 1'b0; CpuAddr = 8'h00;
    LdReq = 1'b0; LdWe = 1'b0; LdAddr = 8'h00; LdWData = 8'h00;
    pre_we = 1'b1; pre_addr = 8'h11; pre_data = 8'h02;
    nxt();
    pre_addr = 8'h12; pre_data = 8'h03;
    nxt();
    pre_we = 1'b0;
    Reset = 1'b0;
    mid();
    chk("rst_stall", {7'd0, CpuStall}, 8'h00);
    chk("rst_gnt",   {7'd0, LdGnt},    8'h00);
    chk("rst_valid", {7'd0, LdValid},  8'h00);
    chk("rst_rdata", LdRData,          8'h00);
    chk("rst_we",    {7'd0, MemWe},    8'h00);
    chk("rst_addr",  MemAddr,          8'h00);

    // Single write of 0xA5 to 0x10.
    nxt();
    LdReq = 1'b1; LdWe = 1'b1; LdAddr = 8'h10; LdWData = 8'hA5;
    mid();
    chk("wr_req_gnt",  {7'd0, LdGnt}, 8'h00);
    chk("wr_req_addr", MemAddr,       8'h00);
    nxt();
    mid();
    chk("wr_gnt",   {7'd0, LdGnt},    8'h01);
    chk("wr_stall", {7'd0, CpuStall}, 8'h01);
    chk("wr_we",    {7'd0, MemWe},    8'h01);
    chk("wr_addr",  MemAddr,          8'h10);
    chk("wr_data",  MemWData,         8'hA5);
    nxt();
    LdReq = 1'b0;
    mid();
    chk("wr_rel_we",  {7'd0, MemWe}, 8'h00);
    chk("wr_rel_gnt", {7'd0, LdGnt}, 8'h01);
    nxt();
    mid();
    chk("ho_gnt",   {7'd0, LdGnt},    8'h00);
    chk("ho_stall", {7'd0, CpuStall}, 8'h01);
    nxt();
    CpuReq = 1'b1; CpuAddr = 8'h10;
    mid();
    chk("cpu_stall", {7'd0, CpuStall}, 8'h00);
    chk("cpu_rd",    CpuRData,         8'hA5);

    // Preload 0x10 = 0x01 while the CPU owns the RAM, then burst-read 0x10..0x12.
    nxt();
    CpuReq = 1'b0; CpuAddr = 8'h00;
    pre_we = 1'b1; pre_addr = 8'h10; pre_data = 8'h01;
    nxt();
    pre_we = 1'b0;
    LdReq = 1'b1; LdWe = 1'b0; LdAddr = 8'h10;
    nxt();
    mid();
    chk("rb_gnt",    {7'd0, LdGnt},   8'h01);
    chk("rb_valid0", {7'd0, LdValid}, 8'h00);
    nxt();
    LdAddr = 8'h11;
    mid();
    chk("rb_valid1", {7'd0, LdValid}, 8'h01);
    chk("rb_data1",  LdRData,         8'h01);
    nxt();
    LdAddr = 8'h12;
    mid();
    chk("rb_valid2", {7'd0, LdValid}, 8'h01);
    chk("rb_data2",  LdRData,         8'h02);
    nxt();
    LdReq = 1'b0;
    mid();
    chk("rb_valid3", {7'd0, LdValid}, 8'h01);
    chk("rb_data3",  LdRData,         8'h03);
    nxt();
    mid();
    chk("rb_ho_stall", {7'd0, CpuStall}, 8'h01);
    chk("rb_ho_valid", {7'd0, LdValid},  8'h00);
    chk("rb_hold",     LdRData,          8'h03);
    nxt();
    mid();
    chk("rb_cpu_stall", {7'd0, CpuStall}, 8'h00);

    // Contention: CPU and loader request together.
    nxt();
    CpuReq = 1'b1; CpuAddr = 8'h05; LdReq = 1'b1; LdWe = 1'b0; LdAddr = 8'h20;
    mid();
    chk("ct_addr",  MemAddr,          8'h05);
    chk("ct_stall", {7'd0, CpuStall}, 8'h00);
    nxt();
    mid();
    chk("ct_stall1", {7'd0, CpuStall}, 8'h01);
    chk("ct_addr1",  MemAddr,          8'h20);

`ifdef ARB_FAIR_EN
    // Beats 1..4 accepted (one checked above), then forced HANDOVER.
    for (int i = 2; i <= 4; i++) begin
      nxt();
      mid();
      chk("fair_gnt", {7'd0, LdGnt}, 8'h01);
    end
    nxt();
    mid();
    chk("fair_ho_gnt",   {7'd0, LdGnt},    8'h00);
    chk("fair_ho_stall", {7'd0, CpuStall}, 8'h01);
    chk("fair_ho_valid", {7'd0, LdValid},  8'h01);
    nxt();
    mid();
    chk("fair_cpu_stall", {7'd0, CpuStall}, 8'h00);
    chk("fair_cpu_gnt",   {7'd0, LdGnt},    8'h00);
    nxt();
    mid();
    chk("fair_regrant", {7'd0, LdGnt}, 8'h01);
`else
    // Strict priority: the grant persists while LdReq stays high.
    for (int i = 2; i <= 8; i++) begin
      nxt();
      mid();
      chk("hold_gnt", {7'd0, LdGnt}, 8'h01);
    end
`endif
    nxt();
    LdReq = 1'b0; CpuReq = 1'b0;
    nxt();
    mid();
    chk("end_ho_stall", {7'd0, CpuStall}, 8'h01);
    nxt();
    mid();
    chk("end_cpu_stall", {7'd0, CpuStall}, 8'h00);

    // Reset while a read burst is in progress.
    nxt();
    LdReq = 1'b1; LdWe = 1'b0; LdAddr = 8'h11;
    nxt();
    nxt();
    Reset = 1'b1; LdWe = 1'b1; LdWData = 8'h5A;
    mid();
    chk("mr_gnt",   {7'd0, LdGnt},   8'h01);
    chk("mr_valid", {7'd0, LdValid}, 8'h01);
    nxt();
    Reset = 1'b0;
    mid();
    chk("mr_rst_valid", {7'd0, LdValid},  8'h00);
    chk("mr_rst_we",    {7'd0, MemWe},    8'h00);
    chk("mr_rst_gnt",   {7'd0, LdGnt},    8'h00);
    chk("mr_rst_stall", {7'd0, CpuStall}, 8'h00);
    chk("mr_rst_rdata", LdRData,          8'h00);
    nxt();
    LdReq = 1'b0;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
